filter_ctrl_sched: RTL and testbench

//  AXI4-Lite control slave and frame sequencer for the 3x3 convolution image filter.
//  - Holds the CTRL, STATUS, FILTER and PIXCNT registers.
//  - Drives the datapath enable, clear and kernel weights.
//  - Watches the output stream handshakes and declares one frame DONE.
//  - Sits beside the filter datapath; firmware polls STATUS.

---
 rtl/filter_ctrl_sched_pkg.sv | 26 ++
 rtl/filter_ctrl_sched_if.sv | 32 +++
 rtl/filter_ctrl_axil_slave.sv | 79 +++++++
 rtl/filter_ctrl_sched.sv | 154 +++++++++++++++
 tb/tb_filter_ctrl_sched.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_ctrl_sched_pkg.sv
// Shared constants and types for the convolution filter control block:
// register offsets, STATUS codes, FSM state type and kernel reset value.
package filter_ctrl_pkg;

  localparam int unsigned KERNEL_W = 27;
  localparam logic [KERNEL_W-1:0] KERNEL_IDENTITY = 27'h0001000;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_FILTER = 4'h8;
  localparam logic [3:0] REG_PIXCNT = 4'hC;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // State encoding doubles as the STATUS register value.
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/filter_ctrl_sched_if.sv
// AXI4-Lite control channel bundle for the filter control slave.
interface filter_ctrl_sched_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/filter_ctrl_axil_slave.sv
// AXI4-Lite handshake engine: independent AW/W holding registers, a one-cycle
// register write strobe, and a registered read response from a rd_addr lookup.
module filter_ctrl_axil_slave
  import filter_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  filter_ctrl_sched_if.slave  axil,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data
);

  logic              live;
  logic              aw_held;
  logic              w_held;
  logic              bvalid_q;
  logic              rvalid_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [DATA_W-1:0] rdata_q;

  // live keeps every ready low until the first clock after reset releases.
  assign axil.awready = live & ~aw_held;
  assign axil.wready  = live & ~w_held;
  assign axil.arready = live & ~rvalid_q;
  assign axil.bvalid  = bvalid_q;
  assign axil.bresp   = RESP_OKAY;
  assign axil.rvalid  = rvalid_q;
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = RESP_OKAY;

  assign wr_en   = aw_held & w_held & ~bvalid_q;
  assign wr_addr = aw_addr_q;
  assign wr_data = w_data_q;
  assign rd_addr = axil.araddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live      <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      rdata_q   <= '0;
    end else begin
      live <= 1'b1;
      if (axil.awvalid && axil.awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= axil.awaddr;
      end
      if (axil.wvalid && axil.wready) begin
        w_held   <= 1'b1;
        w_data_q <= axil.wdata;
      end
      if (wr_en) begin
        bvalid_q <= 1'b1;
      end else if (bvalid_q && axil.bready) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
      if (axil.arvalid && axil.arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
      end else if (rvalid_q && axil.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/filter_ctrl_sched.sv
// Control registers and frame sequencer for the 3x3 convolution filter.
// Optional done interrupt enabled by defining FILTER_CTRL_IRQ_EN.
module filter_ctrl_sched
  import filter_ctrl_pkg::*;
#(
  parameter int unsigned AXI_CONTROL_DATA_WIDTH = 32,
  parameter int unsigned AXI_CONTROL_ADDR_WIDTH = 4,
  parameter int unsigned IMAGE_WIDTH_SIZE       = 512,
  parameter int unsigned IMAGE_WIDTH_LOG2_SIZE  = 9
) (
  input  logic                clk,
  input  logic                rst,
  filter_ctrl_sched_if.slave  s_axi_control,
  input  logic                out_fire,
  input  logic                out_tlast,
  output logic                core_en,
  output logic                core_clear,
  output logic [KERNEL_W-1:0] kernel,
  output logic                irq
);

  // Counts up to a full square frame: 2*log2(width)+1 bits.
  localparam int unsigned PIXCNT_W = $clog2(IMAGE_WIDTH_SIZE) + IMAGE_WIDTH_LOG2_SIZE + 1;

  logic                              wr_en;
  logic [AXI_CONTROL_ADDR_WIDTH-1:0] wr_addr;
  logic [AXI_CONTROL_DATA_WIDTH-1:0] wr_data;
  logic [AXI_CONTROL_ADDR_WIDTH-1:0] rd_addr;
  logic [AXI_CONTROL_DATA_WIDTH-1:0] rd_data;

  state_t                state_q, state_d;
  logic                  clear_d;
  logic                  pix_clr;
  logic                  core_clear_q;
  logic [KERNEL_W-1:0]   kernel_q;
  logic [PIXCNT_W-1:0]   pixcnt_q;
  logic                  ctrl_start_q;
  logic                  ctrl_wr;
  logic                  filt_wr;
  logic                  unused_ok;

  filter_ctrl_axil_slave #(
    .ADDR_W (AXI_CONTROL_ADDR_WIDTH),
    .DATA_W (AXI_CONTROL_DATA_WIDTH)
  ) u_axil (
    .clk     (clk),
    .rst     (rst),
    .axil    (s_axi_control),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign ctrl_wr    = wr_en && (wr_addr == REG_CTRL);
  assign filt_wr    = wr_en && (wr_addr == REG_FILTER);
  assign core_en    = (state_q == S_BUSY);
  assign core_clear = core_clear_q;
  assign kernel     = kernel_q;
  assign unused_ok  = &{1'b0, wr_data};

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    pix_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && wr_data[0]) begin
          state_d = S_BUSY;
          pix_clr = 1'b1;
        end
      end
      S_BUSY: begin
        // An abort write takes priority over a coincident final beat.
        if (ctrl_wr && !wr_data[0]) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
        end else if (out_fire && out_tlast) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ctrl_wr && !wr_data[0]) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      core_clear_q <= 1'b0;
      kernel_q     <= KERNEL_IDENTITY;
      pixcnt_q     <= '0;
      ctrl_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_clear_q <= clear_d;
      if (pix_clr) begin
        pixcnt_q <= '0;
      end else if (state_q == S_BUSY && out_fire && pixcnt_q != '1) begin
        pixcnt_q <= pixcnt_q + 1'b1;
      end
      if (ctrl_wr && !(wr_data[0] && state_q != S_IDLE)) begin
        ctrl_start_q <= wr_data[0];
      end
      if (filt_wr && state_q != S_BUSY) begin
        kernel_q <= wr_data[KERNEL_W-1:0];
      end
    end
  end

`ifdef FILTER_CTRL_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en_q <= wr_data[1];
      end
      irq_q <= (state_q == S_DONE) && irq_en_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_CTRL: begin
`ifdef FILTER_CTRL_IRQ_EN
        rd_data[1] = irq_en_q;
`endif
        rd_data[0] = ctrl_start_q;
      end
      REG_STATUS: rd_data[1:0]          = state_q;
      REG_FILTER: rd_data[KERNEL_W-1:0] = kernel_q;
      REG_PIXCNT: rd_data[PIXCNT_W-1:0] = pixcnt_q;
      default:    rd_data               = '0;
    endcase
  end

endmodule

// File: tb/tb_filter_ctrl_sched.sv
// Self-checking bench for filter_ctrl_sched against a register/frame-level model.
module tb_filter_ctrl_sched;
  import filter_ctrl_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                out_fire = 1'b0;
  logic                out_tlast = 1'b0;
  logic                core_en;
  logic                core_clear;
  logic [KERNEL_W-1:0] kernel;
  logic                irq;

  filter_ctrl_sched_if bus ();

  filter_ctrl_sched #(
    .AXI_CONTROL_DATA_WIDTH (32),
    .AXI_CONTROL_ADDR_WIDTH (4),
    .IMAGE_WIDTH_SIZE       (512),
    .IMAGE_WIDTH_LOG2_SIZE  (9)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_control (bus),
    .out_fire      (out_fire),
    .out_tlast     (out_tlast),
    .core_en       (core_en),
    .core_clear    (core_clear),
    .kernel        (kernel),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int clear_cnt = 0;

  always @(negedge clk) if (core_clear === 1'b1) clear_cnt++;

  // Behavioural model: 0 idle, 1 busy, 2 done
  int          m_state;
  int unsigned m_pix;
  logic [26:0] m_kernel;
  bit          m_irq_en;
  bit          m_start;
  int          m_clears = 0;
  localparam int unsigned PIX_MAX = (1 << 19) - 1;

  function automatic void model_reset();
    m_state = 0; m_pix = 0; m_kernel = 27'h0001000; m_irq_en = 0; m_start = 0;
  endfunction

  function automatic void model_write(input logic [3:0] a, input logic [31:0] d);
    if (a == 4'h0) begin
      if (d[0]) begin
        if (m_state == 0) begin m_state = 1; m_pix = 0; m_start = 1; end
      end else begin
        if (m_state != 0) begin m_state = 0; m_clears++; end
        m_start = 0;
      end
`ifdef FILTER_CTRL_IRQ_EN
      m_irq_en = d[1];
`endif
    end else if (a == 4'h8) begin
      if (m_state != 1) m_kernel = d[26:0];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'h0: return {30'd0, m_irq_en, m_start};
      4'h4: return m_state;
      4'h8: return {5'd0, m_kernel};
      4'hC: return m_pix;
      default: return 32'd0;
    endcase
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input int aw_dly,
                           input int w_dly, output int bcount, output logic [1:0] resp);
    bit done = 0;
    bit aw_hs, w_hs, b_hs;
    bcount = 0;
    resp = 2'bxx;
    bus.bready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (i == aw_dly) begin bus.awvalid = 1'b1; bus.awaddr = a; end
      if (i == w_dly)  begin bus.wvalid = 1'b1; bus.wdata = d; end
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      b_hs  = bus.bvalid && bus.bready;
      if (b_hs) begin bcount++; resp = bus.bresp; end
      @(posedge clk); #1;
      if (aw_hs) bus.awvalid = 1'b0;
      if (w_hs)  bus.wvalid = 1'b0;
      if (b_hs)  done = 1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL write_timeout addr=%h got no bresp, required one", a);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.bvalid === 1'b1) bcount++;
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int bc;
    logic [1:0] resp;
    axi_write(a, d, 0, 0, bc, resp);
    model_write(a, d);
  endtask

  task automatic axi_read(input logic [3:0] a, input int dly, output logic [31:0] data,
                          output bit stable);
    bit done = 0, first = 1, ar_hs, r_hs;
    int held = 0;
    stable = 1;
    data = 'x;
    bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      ar_hs = bus.arvalid && bus.arready;
      if (bus.rvalid) begin
        if (first) begin data = bus.rdata; first = 0; end
        else if (bus.rdata !== data) stable = 0;
        if (held >= dly) bus.rready = 1'b1;
        held++;
      end
      r_hs = bus.rvalid && bus.rready;
      @(posedge clk); #1;
      if (ar_hs) bus.arvalid = 1'b0;
      if (r_hs) begin done = 1; bus.rready = 1'b0; end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL read_timeout addr=%h got no rvalid, required one", a);
      bus.arvalid = 1'b0; bus.rready = 1'b0;
    end
  endtask

  task automatic check_reg(input string name, input logic [3:0] a);
    logic [31:0] d, exp;
    bit st;
    axi_read(a, 0, d, st);
    exp = model_read(a);
    tests++;
    if (d !== exp) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, d, exp);
    end
  endtask

  task automatic drive_frame(input int n, input bit with_last);
    for (int k = 0; k < n; k++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        out_fire = 1'b0; out_tlast = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      out_fire = 1'b1;
      out_tlast = with_last && (k == n - 1);
      if (m_state == 1) begin
        if (m_pix < PIX_MAX) m_pix++;
        if (out_tlast) m_state = 2;
      end
      @(posedge clk); #1;
      out_fire = 1'b0; out_tlast = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (core_en !== 1'b0 || core_clear !== 1'b0 || irq !== 1'b0 || kernel !== 27'h0001000) begin
      fails++;
      $display("FAIL reset_outputs got en=%b clr=%b irq=%b kernel=%h required 0 0 0 0001000",
               core_en, core_clear, irq, kernel);
    end
    tests++;
    if (bus.awready !== 1'b0 || bus.wready !== 1'b0 || bus.arready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got aw=%b w=%b ar=%b required 0", bus.awready, bus.wready, bus.arready);
    end
    cycles(3);
    rst = 1'b0;
    tests++;
    if (bus.awready !== 1'b0) begin
      fails++; $display("FAIL ready_before_clk got %b required 0", bus.awready);
    end
    cycles(1);
    tests++;
    if (bus.awready !== 1'b1 || bus.wready !== 1'b1 || bus.arready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_clk got aw=%b w=%b ar=%b required 1", bus.awready, bus.wready, bus.arready);
    end
    check_reg("reset_status", 4'h4);
    check_reg("reset_filter", 4'h8);
    check_reg("reset_pixcnt", 4'hC);
    check_reg("reset_ctrl", 4'h0);
  endtask

  task automatic test_filter();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      d = (i == 0) ? 32'h0004A91 : $urandom;
      wr(4'h8, d);
      check_reg("filter_readback", 4'h8);
      tests++;
      if (kernel !== m_kernel) begin
        fails++; $display("FAIL filter_kernel got=%h required=%h", kernel, m_kernel);
      end
    end
    wr(4'h1, $urandom);
    wr(4'h4, 32'h3);
    wr(4'hC, $urandom);
    check_reg("unmapped_1", 4'h1);
    check_reg("unmapped_6", 4'h6);
    check_reg("unmapped_D", 4'hD);
    check_reg("status_after_ro_write", 4'h4);
    check_reg("pixcnt_after_ro_write", 4'hC);
    check_reg("filter_after_unmapped", 4'h8);
  endtask

  task automatic test_frame();
    int n;
    for (int f = 0; f < 3; f++) begin
      n = (f == 0) ? 1 : int'($urandom_range(2, 150));
      wr(4'h0, 32'h1);
      check_reg("frame_status_busy", 4'h4);
      check_reg("frame_ctrl", 4'h0);
      tests++;
      if (core_en !== 1'b1) begin fails++; $display("FAIL frame_core_en got %b required 1", core_en); end
      drive_frame(n, 1);
      tests++;
      if (core_en !== 1'b0) begin fails++; $display("FAIL frame_core_en_done got %b required 0", core_en); end
      check_reg("frame_status_done", 4'h4);
      check_reg("frame_pixcnt", 4'hC);
      drive_frame(3, 1);
      check_reg("done_pixcnt_held", 4'hC);
      wr(4'h0, 32'h1);
      check_reg("done_restart_ignored", 4'h4);
      wr(4'h0, 32'h0);
      check_reg("frame_status_idle", 4'h4);
      tests++;
      if (clear_cnt != m_clears) begin
        fails++; $display("FAIL done_clear_count got=%0d required=%0d", clear_cnt, m_clears);
      end
      drive_frame(2, 0);
      check_reg("idle_pixcnt_held", 4'hC);
    end
  endtask

  task automatic test_busy();
    int bc;
    logic [1:0] resp;
    wr(4'h0, 32'h1);
    drive_frame(5, 0);
    axi_write(4'h8, 32'h7FFFFFF, 0, 0, bc, resp);
    model_write(4'h8, 32'h7FFFFFF);
    tests++;
    if (resp !== RESP_OKAY || bc != 1) begin
      fails++; $display("FAIL busy_filter_resp got resp=%b count=%0d required 00 1", resp, bc);
    end
    tests++;
    if (kernel !== m_kernel) begin
      fails++; $display("FAIL busy_kernel got=%h required=%h", kernel, m_kernel);
    end
    wr(4'h0, 32'h1);
    check_reg("busy_restart_ignored", 4'h4);
    wr(4'h0, 32'h0);
    check_reg("abort_status", 4'h4);
    check_reg("abort_pixcnt", 4'hC);
    tests++;
    if (clear_cnt != m_clears) begin
      fails++; $display("FAIL abort_clear_count got=%0d required=%0d", clear_cnt, m_clears);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    logic [1:0] resp;
    logic [31:0] d, rd, old;
    bit st;
    for (int o = 0; o < 2; o++) begin
      d = $urandom;
      axi_write(4'h8, d, (o == 0) ? 0 : 3, (o == 0) ? 3 : 0, bc, resp);
      model_write(4'h8, d);
      tests++;
      if (bc != 1 || resp !== RESP_OKAY) begin
        fails++; $display("FAIL split_bresp order=%0d got count=%0d resp=%b required 1 00", o, bc, resp);
      end
      check_reg("split_readback", 4'h8);
    end
    axi_read(4'h8, 5, rd, st);
    tests++;
    if (!st || rd !== model_read(4'h8)) begin
      fails++; $display("FAIL rready_delay got data=%h stable=%0d required %h 1", rd, st, model_read(4'h8));
    end
    // Read hits the register on the same edge the write lands.
    old = model_read(4'h8);
    d = $urandom;
    bus.awvalid = 1'b1; bus.awaddr = 4'h8; bus.wvalid = 1'b1; bus.wdata = d; bus.bready = 1'b0;
    cycles(1);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 4'h8; bus.rready = 1'b0;
    cycles(1);
    bus.arvalid = 1'b0;
    model_write(4'h8, d);
    tests++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== old) begin
      fails++; $display("FAIL rd_wr_collision got rvalid=%b data=%h required 1 %h", bus.rvalid, bus.rdata, old);
    end
    bus.rready = 1'b1; bus.bready = 1'b1;
    cycles(2);
    bus.rready = 1'b0;
    cycles(2);
    check_reg("collision_write_landed", 4'h8);
  endtask

  task automatic test_irq_reset();
    logic [31:0] d;
    wr(4'h0, 32'h3);
    check_reg("irq_ctrl_readback", 4'h0);
    drive_frame(int'($urandom_range(1, 40)), 1);
    cycles(2);
    tests++;
`ifdef FILTER_CTRL_IRQ_EN
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_done got %b required 1", irq); end
`else
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_tied got %b required 0", irq); end
`endif
    wr(4'h0, 32'h0);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear got %b required 0", irq); end

    d = $urandom;
    wr(4'h8, d);
    wr(4'h0, 32'h1);
    drive_frame(4, 0);
    bus.arvalid = 1'b1; bus.araddr = 4'h4; bus.rready = 1'b0;
    cycles(1);
    bus.arvalid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (bus.rvalid !== 1'b0 || core_en !== 1'b0 || kernel !== m_kernel || irq !== 1'b0) begin
      fails++;
      $display("FAIL midreset got rvalid=%b en=%b kernel=%h irq=%b required 0 0 %h 0",
               bus.rvalid, core_en, kernel, irq, m_kernel);
    end
    cycles(2);
    rst = 1'b0;
    cycles(1);
    check_reg("midreset_status", 4'h4);
    check_reg("midreset_filter", 4'h8);
    check_reg("midreset_pixcnt", 4'hC);
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
    model_reset();
    test_reset();
    test_filter();
    test_frame();
    test_busy();
    test_back_to_back();
    test_irq_reset();
    do_reset();
    cycles(1);
    check_reg("final_status", 4'h4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
